// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between two requesters.
// Two-stage pipe: grant -> registered RAM access (stage A) -> response pulse (stage B).
module data_ram_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic            m0_req_write,
    input  logic [XLEN-1:0] m0_req_addr,
    input  logic [XLEN-1:0] m0_req_wdata,
    output logic            m0_rsp_valid,
    output logic [XLEN-1:0] m0_rsp_rdata,
    output logic            m0_rsp_err,
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic            m1_req_write,
    input  logic [XLEN-1:0] m1_req_addr,
    input  logic [XLEN-1:0] m1_req_wdata,
    output logic            m1_rsp_valid,
    output logic [XLEN-1:0] m1_rsp_rdata,
    output logic            m1_rsp_err,
    output logic            ram_write_enable,
    output logic [XLEN-1:0] ram_address,
    output logic [XLEN-1:0] ram_write_data,
    input  logic [XLEN-1:0] ram_read_data
);
    localparam int LSB = $clog2(XLEN / 8);

    logic            last_grant_q, last_grant_d;
    logic            a_valid_q, a_valid_d;
    logic            a_port_q, a_port_d;
    logic            a_write_q, a_write_d;
    logic            a_err_q, a_err_d;
    logic            a_we_q, a_we_d;
    logic [XLEN-1:0] a_addr_q, a_addr_d;
    logic [XLEN-1:0] a_wdata_q, a_wdata_d;
    logic            b_valid_q, b_valid_d;
    logic            b_port_q, b_port_d;
    logic            b_err_q, b_err_d;
    logic [XLEN-1:0] b_rdata_q, b_rdata_d;

    logic            grant0, grant1, handshake, sel_port, sel_write, sel_err;
    logic [XLEN-1:0] sel_addr, sel_wdata;

    // last_grant_q names the port that won most recently; on a tie the other port wins.
    always_comb begin
        grant0    = m0_req_valid && !rst && (!m1_req_valid || last_grant_q);
        grant1    = m1_req_valid && !rst && (!m0_req_valid || !last_grant_q);
        handshake = grant0 || grant1;
        sel_port  = grant1;
        sel_write = grant1 ? m1_req_write : m0_req_write;
        sel_addr  = grant1 ? m1_req_addr  : m0_req_addr;
        sel_wdata = grant1 ? m1_req_wdata : m0_req_wdata;
        sel_err   = |sel_addr[LSB-1:0];
    end

    always_comb begin
        last_grant_d = handshake ? sel_port : last_grant_q;
        a_valid_d    = handshake;
        a_port_d     = sel_port;
        a_write_d    = sel_write;
        a_err_d      = sel_err;
        a_we_d       = handshake && sel_write && !sel_err;
        a_addr_d     = handshake ? sel_addr  : a_addr_q;
        a_wdata_d    = handshake ? sel_wdata : a_wdata_q;
        b_valid_d    = a_valid_q;
        b_port_d     = a_port_q;
        b_err_d      = a_err_q;
        b_rdata_d    = (a_valid_q && !a_write_q && !a_err_q) ? ram_read_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            a_valid_q    <= 1'b0;
            a_port_q     <= 1'b0;
            a_write_q    <= 1'b0;
            a_err_q      <= 1'b0;
            a_we_q       <= 1'b0;
            a_addr_q     <= '0;
            a_wdata_q    <= '0;
            b_valid_q    <= 1'b0;
            b_port_q     <= 1'b0;
            b_err_q      <= 1'b0;
            b_rdata_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            a_valid_q    <= a_valid_d;
            a_port_q     <= a_port_d;
            a_write_q    <= a_write_d;
            a_err_q      <= a_err_d;
            a_we_q       <= a_we_d;
            a_addr_q     <= a_addr_d;
            a_wdata_q    <= a_wdata_d;
            b_valid_q    <= b_valid_d;
            b_port_q     <= b_port_d;
            b_err_q      <= b_err_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Masking with rst keeps a store sitting in stage A from committing on the reset edge.
    always_comb begin
        m0_req_ready     = grant0;
        m1_req_ready     = grant1;
        ram_write_enable = a_we_q && !rst;
        ram_address      = a_addr_q;
        ram_write_data   = a_wdata_q;
        m0_rsp_valid     = b_valid_q && !b_port_q && !rst;
        m1_rsp_valid     = b_valid_q && b_port_q && !rst;
        m0_rsp_err       = m0_rsp_valid && b_err_q;
        m1_rsp_err       = m1_rsp_valid && b_err_q;
        m0_rsp_rdata     = m0_rsp_valid ? b_rdata_q : '0;
        m1_rsp_rdata     = m1_rsp_valid ? b_rdata_q : '0;
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (arbitration rule, response queue, memory image).
module tb_data_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_valid = 1'b0, m0_req_ready, m0_req_write = 1'b0;
    logic [31:0] m0_req_addr = '0, m0_req_wdata = '0, m0_rsp_rdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic        m1_req_valid = 1'b0, m1_req_ready, m1_req_write = 1'b0;
    logic [31:0] m1_req_addr = '0, m1_req_wdata = '0, m1_rsp_rdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic        ram_write_enable;
    logic [31:0] ram_address, ram_write_data, ram_read_data;

    data_ram_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Stand-in for data_ram: combinational read, write committed at the clock edge.
    logic [31:0] mem [256] = '{default: 32'h0};
    assign ram_read_data = mem[ram_address[9:2]];
    always @(posedge clk) if (ram_write_enable) mem[ram_address[9:2]] <= ram_write_data;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        respQ[$];
    logic [31:0] refMem [256] = '{default: 32'h0};
    int          total = 0, bad = 0, cycle = 0;
    int          lastWin = 1;
    logic        pValid [2] = '{1'b0, 1'b0};
    logic        pWrite [2] = '{1'b0, 1'b0};
    logic [31:0] pAddr  [2] = '{32'h0, 32'h0};
    logic [31:0] pWdata [2] = '{32'h0, 32'h0};
    logic        expWe = 1'b0, expWeNext = 1'b0;
    logic [31:0] expAddr = '0, expAddrNext = '0, expWdata = '0, expWdataNext = '0;
    logic [1:0]  obsReady;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s at cycle %0d: observed=%h expected=%h", tag, cycle, obs, expv);
        end
    endtask

    task automatic applyStimulus();
        m0_req_valid = pValid[0]; m0_req_write = pWrite[0];
        m0_req_addr  = pAddr[0];  m0_req_wdata = pWdata[0];
        m1_req_valid = pValid[1]; m1_req_write = pWrite[1];
        m1_req_addr  = pAddr[1];  m1_req_wdata = pWdata[1];
    endtask

    task automatic setReq(input int p, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        pValid[p] = 1'b1; pWrite[p] = wr; pAddr[p] = addr; pWdata[p] = wdata;
    endtask

    // Model of one accepted request: memory image updated in grant order, response due two cycles later.
    task automatic accept(input int p);
        rsp_t r;
        r.due = cycle + 2; r.port = p; r.rdata = '0; r.err = (pAddr[p][1:0] != 2'b00);
        if (!r.err && pWrite[p]) begin
            refMem[pAddr[p][9:2]] = pWdata[p];
            expWeNext = 1'b1;
        end else if (!r.err) begin
            r.rdata = refMem[pAddr[p][9:2]];
        end
        respQ.push_back(r);
        lastWin = p; pValid[p] = 1'b0;
        expAddrNext = pAddr[p]; expWdataNext = pWdata[p];
    endtask

    task automatic runCycle();
        logic        e [2];
        logic        ev [2];
        logic        eerr [2];
        logic [31:0] erd [2];
        rsp_t        r;
        applyStimulus();
        @(negedge clk);
        obsReady = {m1_req_ready, m0_req_ready};
        if (rst) begin
            checkOutput("rst_ready", {30'b0, obsReady}, 32'h0);
            checkOutput("rst_rsp_valid", {30'b0, m1_rsp_valid, m0_rsp_valid}, 32'h0);
            checkOutput("rst_we", {31'b0, ram_write_enable}, 32'h0);
            respQ.delete();
            lastWin = 1; expWeNext = 1'b0; expAddrNext = '0; expWdataNext = '0;
        end else begin
            e[0] = pValid[0] && (!pValid[1] || lastWin == 1);
            e[1] = pValid[1] && (!pValid[0] || lastWin == 0);
            checkOutput("m0_req_ready", {31'b0, m0_req_ready}, {31'b0, e[0]});
            checkOutput("m1_req_ready", {31'b0, m1_req_ready}, {31'b0, e[1]});
            ev = '{1'b0, 1'b0}; eerr = '{1'b0, 1'b0}; erd = '{32'h0, 32'h0};
            if (respQ.size() > 0 && respQ[0].due == cycle) begin
                r = respQ.pop_front();
                ev[r.port] = 1'b1; eerr[r.port] = r.err; erd[r.port] = r.rdata;
            end
            checkOutput("m0_rsp_valid", {31'b0, m0_rsp_valid}, {31'b0, ev[0]});
            checkOutput("m0_rsp_err", {31'b0, m0_rsp_err}, {31'b0, eerr[0]});
            checkOutput("m0_rsp_rdata", m0_rsp_rdata, erd[0]);
            checkOutput("m1_rsp_valid", {31'b0, m1_rsp_valid}, {31'b0, ev[1]});
            checkOutput("m1_rsp_err", {31'b0, m1_rsp_err}, {31'b0, eerr[1]});
            checkOutput("m1_rsp_rdata", m1_rsp_rdata, erd[1]);
            checkOutput("ram_write_enable", {31'b0, ram_write_enable}, {31'b0, expWe});
            checkOutput("ram_address", ram_address, expAddr);
            checkOutput("ram_write_data", ram_write_data, expWdata);
            expWeNext = 1'b0; expAddrNext = expAddr; expWdataNext = expWdata;
            if (e[0]) accept(0);
            else if (e[1]) accept(1);
        end
        @(posedge clk);
        cycle++;
        expWe = expWeNext; expAddr = expAddrNext; expWdata = expWdataNext;
        #1;
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1; pValid = '{1'b0, 1'b0};
        repeat (n) runCycle();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) runCycle();
    endtask

    initial begin
        $display("[TB] start");
        applyReset(2);

        // Store then load of the same word: load must see the stored value.
        setReq(0, 1'b1, 32'h10, 32'hDEADBEEF);
        runCycle();
        setReq(0, 1'b0, 32'h10, 32'h0);
        runCycle();
        drain(3);
        checkOutput("t1_mem_0x10", mem[4], 32'hDEADBEEF);

        // Continuous contention from reset: grants alternate starting with port 0.
        applyReset(1);
        for (int i = 0; i < 6; i++) begin
            if (!pValid[0]) setReq(0, 1'b0, 32'(i * 4), 32'h0);
            if (!pValid[1]) setReq(1, 1'b0, 32'h10, 32'h0);
            runCycle();
            checkOutput("t3_grant", {30'b0, obsReady}, (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        pValid = '{1'b0, 1'b0};
        drain(3);

        // Misaligned store: error response, RAM untouched.
        setReq(1, 1'b1, 32'h13, 32'h12345678);
        runCycle();
        drain(3);
        checkOutput("t4_mem_0x10", mem[4], 32'hDEADBEEF);

        // Back-to-back store on port 0 and load on port 1 of the same address.
        setReq(0, 1'b1, 32'h20, 32'h55);
        runCycle();
        setReq(1, 1'b0, 32'h20, 32'h0);
        runCycle();
        drain(3);
        checkOutput("t5_mem_0x20", mem[8], 32'h55);

        // Reset while a store occupies stage A: store must never commit.
        setReq(0, 1'b1, 32'h40, 32'hAAAA5555);
        runCycle();
        applyReset(2);
        drain(3);
        checkOutput("t6_mem_0x40", mem[16], 32'h0);
        refMem[16] = 32'h0;

        // Random traffic from both ports, including misaligned addresses.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pValid[p] && ($urandom % 3 != 0)) begin
                    setReq(p, 1'($urandom % 2),
                           {22'b0, 8'($urandom_range(0, 31)),
                            ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
                           $urandom);
                end
            end
            runCycle();
        end
        pValid = '{1'b0, 1'b0};
        drain(3);
        for (int w = 0; w < 32; w++) checkOutput("final_mem", mem[w], refMem[w]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
